// File: rtl/nn_pkg.sv
// nn_pkg: shared controller state encoding, default data width and address-width helper
package nn_pkg;
  typedef enum logic [2:0] {LOAD, COMPUTE, WAIT, YLD, OUT} ctrl_state_t;
  localparam int T = 16;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mvm_layer_ctrl_if.sv
// mvm_layer_ctrl_if: stream handshakes plus memory/MAC control lines of one MVM layer
interface mvm_layer_ctrl_if #(
  parameter int AWX = 3,
  parameter int AWW = 6
);
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;
  logic x_we;
  logic [AWX-1:0] x_addr;
  logic [AWW-1:0] w_addr;
  logic mac_en;
  logic mac_clear;
  logic y_load;
  modport master (
    input s_valid, m_ready,
    output s_ready, m_valid, x_we, x_addr, w_addr, mac_en, mac_clear, y_load
  );
  modport slave (
    output s_valid, m_ready,
    input s_ready, m_valid, x_we, x_addr, w_addr, mac_en, mac_clear, y_load
  );
endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MAX up counter that wraps explicitly and flags its final value
module wrap_counter #(
  parameter int MAX = 2,
  parameter int W = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic [W-1:0] count,
  output logic last
);
  assign last = count == W'(MAX - 1);
  // count up on inc, returning to zero after MAX-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= last ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/mvm_layer_ctrl.sv
// mvm_layer_ctrl: sequencing FSM for one y = f(W*x) layer; memories, MAC and ReLU live outside
module mvm_layer_ctrl import nn_pkg::*; #(
  parameter int M = 8,
  parameter int N = 6,
  parameter int T = nn_pkg::T,
  parameter int AWX = clog2_min1(N),
  parameter int AWW = clog2_min1(M * N)
) (
  input logic clk,
  input logic reset,
  mvm_layer_ctrl_if.master bus
);
  localparam int AWR = clog2_min1(M);
  ctrl_state_t state;
  logic [AWX-1:0] col;
  logic [AWR-1:0] row;
  logic col_last, row_last, s_hs, m_hs;
  if (M < 1 || N < 1 || T < 1) begin : g_bad_params
    $error("mvm_layer_ctrl: M, N and T must all be at least 1");
  end
  assign s_hs = bus.s_valid & bus.s_ready;
  assign m_hs = bus.m_valid & bus.m_ready;
  assign bus.x_we = s_hs;
  assign bus.x_addr = col;
  wrap_counter #(.MAX(N), .W(AWX)) u_col (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(s_hs | (state == COMPUTE)),
    .count(col), .last(col_last)
  );
  wrap_counter #(.MAX(M), .W(AWR)) u_row (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(m_hs),
    .count(row), .last(row_last)
  );
  // control FSM; MAC enables trail the address they consume by one cycle to match memory latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      bus.w_addr <= '0;
      bus.s_ready <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.mac_en <= 1'b0;
      bus.mac_clear <= 1'b0;
      bus.y_load <= 1'b0;
    end else begin
      bus.mac_en <= state == COMPUTE;
      bus.mac_clear <= state == COMPUTE && col == '0;
      bus.y_load <= state == WAIT;
      case (state)
        LOAD: begin
          bus.s_ready <= !(s_hs && col_last);
          if (s_hs && col_last) state <= COMPUTE;
        end
        COMPUTE: begin
          bus.w_addr <= (col_last && row == AWR'(M - 1)) ? '0 : bus.w_addr + 1'b1;
          if (col_last) state <= WAIT;
        end
        WAIT: state <= YLD;
        YLD: begin
          state <= OUT;
          bus.m_valid <= 1'b1;
        end
        OUT: if (bus.m_ready) begin
          bus.m_valid <= 1'b0;
          bus.s_ready <= row_last;
          state <= row_last ? LOAD : COMPUTE;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mvm_layer_ctrl.sv
// tb_mvm_layer_ctrl: directed and randomized checks of the layer controller against a ReLU(W*x) model
module tb_mvm_layer_ctrl;
  typedef logic signed [15:0] vec_t [6];
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic signed [15:0] s_data;
  int n_cmp = 0, n_bad = 0, n_mhs = 0, k_mon = 0, row_mon = 0;
  longint gq[$];
  logic [2:0] xa_q;
  logic [5:0] wa_q;
  logic signed [15:0] xmem [6];
  logic signed [15:0] x_q, w_q;
  logic signed [31:0] acc, y_reg;
  mvm_layer_ctrl_if #(.AWX(3), .AWW(6)) a();
  mvm_layer_ctrl_if #(.AWX(1), .AWW(1)) b();
  mvm_layer_ctrl #(.M(8), .N(6)) dut (.clk(clk), .reset(rst_a), .bus(a));
  mvm_layer_ctrl #(.M(1), .N(1)) dut1 (.clk(clk), .reset(rst_b), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int wv(input int i);
    return (i * 7) % 11 - 5;
  endfunction
  function automatic longint gold(input vec_t v, input int r);
    longint s = 0;
    for (int c = 0; c < 6; c++) s += longint'(wv(r * 6 + c)) * longint'(v[c]);
    return (s < 0) ? 0 : s;
  endfunction
  function automatic vec_t rand_vec();
    vec_t v;
    for (int c = 0; c < 6; c++) v[c] = 16'(int'($urandom_range(40)) - 20);
    return v;
  endfunction
  task automatic send_vec(input vec_t v, input int pct, input int first);
    int t;
    logic hs;
    for (int c = first; c < 6; c++) begin
      t = 0;
      hs = 1'b0;
      while (!hs && t < 1000) begin
        a.s_valid = int'($urandom_range(99)) < pct;
        s_data = v[c];
        @(negedge clk);
        hs = a.s_valid && a.s_ready;
        if (hs) begin
          check("load_x_we", a.x_we, 1);
          check("load_x_addr", a.x_addr, c);
        end
        @(posedge clk); #1;
        t++;
      end
      if (!hs) check("load_timeout", 0, 1);
    end
    a.s_valid = 1'b0;
    for (int r = 0; r < 8; r++) gq.push_back(gold(v, r));
  endtask
  task automatic drain();
    int t = 0;
    a.m_ready = 1'b1;
    while (!(a.s_ready && gq.size() == 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_done", a.s_ready && gq.size() == 0, 1);
    a.m_ready = 1'b0;
  endtask
  // datapath model: x memory, weight ROM, 1-cycle reads, MAC and ReLU output register
  always @(posedge clk) begin
    if (a.x_we) xmem[a.x_addr] <= s_data;
    x_q <= xmem[a.x_addr];
    w_q <= 16'(wv(int'(a.w_addr)));
    if (a.mac_en) acc <= a.mac_clear ? x_q * w_q : acc + x_q * w_q;
    if (a.y_load) y_reg <= (acc < 0) ? 32'sd0 : acc;
    xa_q <= a.x_addr;
    wa_q <= a.w_addr;
  end
  // address-order and result monitor for the M=8, N=6 instance
  always @(negedge clk) begin
    if (rst_a) begin
      k_mon = 0;
      row_mon = 0;
      gq.delete();
    end else begin
      if (a.mac_en) begin
        check("mon_mac_clear", a.mac_clear, k_mon == 0);
        check("mon_x_rd", xa_q, k_mon);
        check("mon_w_rd", wa_q, row_mon * 6 + k_mon);
        k_mon++;
      end
      if (a.m_valid && a.m_ready) begin
        check("mon_row_len", k_mon, 6);
        if (gq.size() == 0) check("mon_y_unexpected", 0, 1);
        else check("mon_y", y_reg, gq.pop_front());
        k_mon = 0;
        row_mon = (row_mon + 1) % 8;
        n_mhs++;
      end
    end
  end
  initial begin
    vec_t v;
    int t, mh;
    logic done;
    rst_a = 1'b1;
    rst_b = 1'b1;
    a.s_valid = 1'b0;
    a.m_ready = 1'b0;
    b.s_valid = 1'b0;
    b.m_ready = 1'b0;
    s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", a.s_ready, 0);
    check("rst_m_valid", a.m_valid, 0);
    check("rst_mac_en", a.mac_en, 0);
    check("rst_mac_clear", a.mac_clear, 0);
    check("rst_y_load", a.y_load, 0);
    check("rst_x_addr", a.x_addr, 0);
    check("rst_w_addr", a.w_addr, 0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", a.s_ready, 1);
    v = rand_vec();
    send_vec(v, 100, 0);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      check("t1_s_ready", a.s_ready, 0);
      check("t1_w_addr", a.w_addr, (i < 6) ? i : 6);
      check("t1_mac_en", a.mac_en, i >= 1 && i <= 6);
      check("t1_mac_clear", a.mac_clear, i == 1);
      check("t1_y_load", a.y_load, i == 7);
      check("t1_m_valid", a.m_valid, i == 8);
      if (i < 8) begin
        @(posedge clk); #1;
      end
    end
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t2_m_valid", a.m_valid, 1);
      check("t2_w_addr", a.w_addr, 6);
      check("t2_mac_en", a.mac_en, 0);
      check("t2_y_load", a.y_load, 0);
    end
    @(posedge clk); #1;
    a.m_ready = 1'b1;
    @(posedge clk); #1;
    a.m_ready = 1'b0;
    @(negedge clk);
    check("t2_row1_w", a.w_addr, 6);
    check("t2_row1_x", a.x_addr, 0);
    check("t2_m_valid_low", a.m_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_row1_w_next", a.w_addr, 7);
    check("t2_row1_x_next", a.x_addr, 1);
    drain();
    send_vec(rand_vec(), 100, 0);
    v = rand_vec();
    a.s_valid = 1'b1;
    s_data = v[0];
    a.m_ready = 1'b1;
    mh = 0;
    done = 1'b0;
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      if (mh < 8) begin
        check("t5_s_ready", a.s_ready, 0);
        check("t5_x_we", a.x_we, 0);
      end else begin
        check("t5_accept_s_ready", a.s_ready, 1);
        check("t5_accept_x_we", a.x_we, 1);
        check("t5_accept_x_addr", a.x_addr, 0);
        done = 1'b1;
      end
      if (a.m_valid && a.m_ready) mh++;
      @(posedge clk); #1;
      t++;
    end
    if (!done) check("t5_timeout", 0, 1);
    send_vec(v, 100, 1);
    drain();
    n_mhs = 0;
    fork
      begin : s_drv
        for (int n = 0; n < 100; n++) send_vec(rand_vec(), 50, 0);
      end
      begin : m_drv
        int tt;
        tt = 0;
        while (n_mhs < 800 && tt < 30000) begin
          a.m_ready = $urandom_range(1) == 1;
          @(posedge clk); #1;
          tt++;
        end
      end
    join
    a.m_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t3_handshakes", n_mhs, 800);
    check("t3_idle_s_ready", a.s_ready, 1);
    a.m_ready = 1'b0;
    send_vec(rand_vec(), 100, 0);
    a.m_ready = 1'b1;
    t = 0;
    done = 1'b0;
    while (!done && t < 300) begin
      @(posedge clk); #1;
      done = row_mon == 3 && k_mon == 2;
      t++;
    end
    check("t4_reached_row3", done, 1);
    check("t4_mac_before", a.mac_en, 1);
    rst_a = 1'b1;
    #1;
    check("t4_mac_en", a.mac_en, 0);
    check("t4_m_valid", a.m_valid, 0);
    check("t4_s_ready", a.s_ready, 0);
    check("t4_w_addr", a.w_addr, 0);
    check("t4_x_addr", a.x_addr, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    a.m_ready = 1'b0;
    send_vec(rand_vec(), 100, 0);
    @(negedge clk);
    check("t4_first_w", a.w_addr, 0);
    drain();
    rst_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("t6_s_ready", b.s_ready, 1);
    b.s_valid = 1'b1;
    @(negedge clk);
    check("t6_x_we", b.x_we, 1);
    @(posedge clk); #1;
    b.s_valid = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      if (i == 3) b.m_ready = 1'b1;
      @(negedge clk);
      check("t6_s_ready_busy", b.s_ready, 0);
      check("t6_mac_en", b.mac_en, i == 1);
      check("t6_mac_clear", b.mac_clear, i == 1);
      check("t6_y_load", b.y_load, i == 2);
      check("t6_m_valid", b.m_valid, i == 3);
      check("t6_w_addr", b.w_addr, 0);
      @(posedge clk); #1;
    end
    b.m_ready = 1'b0;
    @(negedge clk);
    check("t6_s_ready_back", b.s_ready, 1);
    check("t6_m_valid_low", b.m_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
